// File: rtl/cache_arbiter_pkg.sv
// cache_arbiter_pkg: shared state encodings and size constants for the cache port arbiter
package cache_arbiter_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;
  localparam int MAX_REQ = 4;
  localparam int DEF_AW  = 17;
  localparam int DEF_DW  = 32;
endpackage

// File: rtl/cache_arbiter_rr_pick.sv
// cache_arbiter_rr_pick: combinational winner select, round-robin or fixed priority (ARB_FIXED_PRIO_EN)
module cache_arbiter_rr_pick
  import cache_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic [1:0]         winner,
  output logic               any_req
);
  logic [MAX_REQ-1:0] req_ext;
  assign req_ext = MAX_REQ'(req);
  assign any_req = |req;
`ifdef ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last;
  // lowest set index wins; scanning downward lets the last hit overwrite
  always_comb begin
    winner = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--)
      if (req_ext[i]) winner = 2'(i);
  end
`else
  logic [1:0] idx;
  // first set bit after last, wrapping; scanning the rotation backwards keeps the earliest hit
  always_comb begin
    winner = '0;
    idx    = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = 2'((int'(last) + i) % NUM_REQ);
      if (req_ext[idx]) winner = idx;
    end
  end
`endif
endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one read-only cache port between NUM_REQ requesters (ARB_FIXED_PRIO_EN selects fixed priority)
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [DW-1:0]         req_rdata,
  output logic [AW-1:0]         cache_addr,
  output logic                  cache_valid,
  input  logic [DW-1:0]         cache_rdata,
  input  logic                  cache_ready,
  output logic [1:0]            grant_id
);
  state_t        state_q, state_d;
  logic [1:0]    last, winner;
  logic          any_req;
  logic [AW-1:0] addr_arr [MAX_REQ];

  for (genvar g = 0; g < MAX_REQ; g++) begin : g_addr
    if (g < NUM_REQ) begin : g_on
      assign addr_arr[g] = req_addr[g*AW +: AW];
    end else begin : g_off
      assign addr_arr[g] = '0;
    end
  end

  cache_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (req_valid),
    .last    (last),
    .winner  (winner),
    .any_req (any_req)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;

  // next state: grant on any request, complete on cache_ready, one dead cycle in S_DONE
  always_comb begin
    state_d = S_IDLE;
    state_d = (state_q == S_IDLE) ? (any_req ? S_BUSY : S_IDLE) :
              (state_q == S_BUSY) ? (cache_ready ? S_DONE : S_BUSY) : S_IDLE;
  end

  // grant latch, cache request and response return
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      grant_id    <= '0;
      cache_addr  <= '0;
      cache_valid <= 1'b0;
      req_ready   <= '0;
      req_rdata   <= '0;
    end else begin
      if (state_q == S_IDLE && any_req) begin
        grant_id    <= winner;
        cache_addr  <= addr_arr[winner];
        cache_valid <= 1'b1;
      end
      if (state_q == S_BUSY && cache_ready) begin
        req_rdata   <= cache_rdata;
        req_ready   <= NUM_REQ'(1) << grant_id;
        cache_valid <= 1'b0;
      end
      if (state_q == S_DONE) req_ready <= '0;
    end

`ifdef ARB_FIXED_PRIO_EN
  assign last = 2'(NUM_REQ - 1);
`else
  // rotation pointer advances to the port just served
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                                last <= 2'(NUM_REQ - 1);
    else if (state_q == S_BUSY && cache_ready) last <= grant_id;
`endif

  a_grant_hold: assert property (@(posedge clk) disable iff (!rst_n)
    state_q == S_BUSY |-> (|(req_valid & (NUM_REQ'(1) << grant_id))) && addr_arr[grant_id] == cache_addr);
  a_stray_ready: assert property (@(posedge clk) disable iff (!rst_n)
    cache_ready |-> state_q == S_BUSY);
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: scoreboard bench for cache_arbiter with a latency-programmable cache model
module tb_cache_arbiter;
  localparam int N  = 3;
  localparam int AW = 17;
  localparam int DW = 32;

  logic          clk = 0;
  logic          rst_n = 0;
  logic [N-1:0]  req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]  req_ready;
  logic [DW-1:0] req_rdata;
  logic [AW-1:0] cache_addr;
  logic          cache_valid;
  logic [DW-1:0] cache_rdata = '0;
  logic          cache_ready = 0;
  logic [1:0]    grant_id;

  cache_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .req_rdata(req_rdata), .cache_addr(cache_addr),
    .cache_valid(cache_valid), .cache_rdata(cache_rdata), .cache_ready(cache_ready),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [16:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          compared = 0;
  int          mismatched = 0;
  int          lat = 3;
  int          rem[N];
  logic [16:0] cur[N];
  logic [16:0] seen_addr = '0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] data_of(logic [16:0] a);
    return (a == 17'h00104) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  function automatic void push(int p, logic [16:0] a, logic [31:0] d);
    exp_t e;
    e.port = p;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endfunction

  // cache model: answers lat cycles after seeing cache_valid, checks the request stays put
  initial begin
    bit cbusy;
    bit unstable;
    int cnt;
    cbusy = 0;
    unstable = 0;
    cnt = 0;
    forever begin
      @(negedge clk);
      cache_ready = 0;
      if (!rst_n) cbusy = 0;
      else begin
        if (!cbusy && cache_valid) begin
          cbusy = 1;
          cnt = lat - 1;
          seen_addr = cache_addr;
          unstable = 0;
        end else if (cbusy) begin
          cnt--;
          if (!cache_valid || cache_addr !== seen_addr) unstable = 1;
        end
        if (cbusy && cnt == 0) begin
          check("hold_stable", 32'(unstable), 0);
          cache_ready = 1;
          cache_rdata = data_of(seen_addr);
          cbusy = 0;
        end
      end
    end
  end

  // monitor: every ready pulse is matched against the head of the scoreboard
  initial begin
    bit   prev_rdy;
    exp_t e;
    prev_rdy = 0;
    forever begin
      @(negedge clk);
      if (prev_rdy) check("ready_width", 32'(req_ready), 0);
      prev_rdy = |req_ready;
      if (|req_ready) begin
        if (sb.size() == 0) check("unexpected_ready", 32'(req_ready), 0);
        else begin
          e = sb.pop_front();
          check("ready_port", 32'(req_ready), 32'(1) << e.port);
          check("rdata", req_rdata, e.data);
          check("grant_id", 32'(grant_id), 32'(e.port));
          check("cache_addr", 32'(seen_addr), 32'(e.addr));
          check("valid_drop", 32'(cache_valid), 0);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (req_ready[i] && rem[i] > 0) begin
        rem[i]--;
        if (rem[i] == 0) req_valid[i] = 0;
        else begin
          cur[i] = cur[i] + 17'd4;
          req_addr[i*AW +: AW] = cur[i];
        end
      end
  endtask

  task automatic issue(int p, int n, logic [16:0] a);
    rem[p] = n;
    cur[p] = a;
    req_addr[p*AW +: AW] = a;
    req_valid[p] = 1;
  endtask

  task automatic wait_done(int budget);
    for (int c = 0; c < budget && sb.size() != 0; c++) tick();
    if (sb.size() != 0) begin
      check("timeout_pending", 32'(sb.size()), 0);
      sb.delete();
    end
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      cur[i] = '0;
    end
    repeat (3) tick();
    check("rst_ready", 32'(req_ready), 0);
    check("rst_rdata", req_rdata, 0);
    check("rst_valid", 32'(cache_valid), 0);
    check("rst_addr", 32'(cache_addr), 0);
    check("rst_grant", 32'(grant_id), 0);
    rst_n = 1;
    tick();

    // ports 0 and 1 contend from reset
`ifdef ARB_FIXED_PRIO_EN
    issue(0, 4, 17'h00200);
    issue(1, 1, 17'h00300);
    push(0, 17'h00200, data_of(17'h00200));
    push(0, 17'h00204, data_of(17'h00204));
    push(0, 17'h00208, data_of(17'h00208));
    push(0, 17'h0020C, data_of(17'h0020C));
    push(1, 17'h00300, data_of(17'h00300));
`else
    issue(0, 2, 17'h00200);
    issue(1, 2, 17'h00300);
    push(0, 17'h00200, data_of(17'h00200));
    push(1, 17'h00300, data_of(17'h00300));
    push(0, 17'h00204, data_of(17'h00204));
    push(1, 17'h00304, data_of(17'h00304));
`endif
    wait_done(200);

    // ports 1 and 2 with port 1 served last
    issue(1, 1, 17'h00500);
    issue(2, 1, 17'h00400);
`ifdef ARB_FIXED_PRIO_EN
    push(1, 17'h00500, data_of(17'h00500));
    push(2, 17'h00400, data_of(17'h00400));
`else
    push(2, 17'h00400, data_of(17'h00400));
    push(1, 17'h00500, data_of(17'h00500));
`endif
    wait_done(100);

    // single request on port 0
    issue(0, 1, 17'h00104);
    push(0, 17'h00104, 32'hDEADBEEF);
    wait_done(50);

    // cache busy with its invalidate sweep
    lat = 256;
    issue(0, 1, 17'h00600);
    push(0, 17'h00600, data_of(17'h00600));
    wait_done(400);

    // reset while port 1 is in flight
    lat = 20;
    issue(1, 1, 17'h00800);
    for (int c = 0; c < 10 && !cache_valid; c++) tick();
    repeat (3) tick();
    check("busy_valid", 32'(cache_valid), 1);
    #2 rst_n = 0;
    #1;
    check("arst_valid", 32'(cache_valid), 0);
    check("arst_ready", 32'(req_ready), 0);
    check("arst_grant", 32'(grant_id), 0);
    req_valid = '0;
    for (int i = 0; i < N; i++) rem[i] = 0;
    repeat (2) tick();
    rst_n = 1;
    lat = 3;
    issue(0, 1, 17'h00900);
    issue(1, 1, 17'h00A00);
    push(0, 17'h00900, data_of(17'h00900));
    push(1, 17'h00A00, data_of(17'h00A00));
    wait_done(100);

    // port 1 requesting every cycle against a fast cache
    lat = 1;
    issue(1, 4, 17'h00B00);
    push(1, 17'h00B00, data_of(17'h00B00));
    push(1, 17'h00B04, data_of(17'h00B04));
    push(1, 17'h00B08, data_of(17'h00B08));
    push(1, 17'h00B0C, data_of(17'h00B0C));
    wait_done(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
